// File: rtl/ftc_cdc_handshake_sender.sv
// Source-side four-phase req/ack sender for moving a WIDTH-bit word into an
// asynchronous destination domain.
//   clk, rst          : block clock, asynchronous active-high reset
//   test_mode_async   : collapses the ack synchronizer to a single stage
//   src_valid/ready   : word handshake from the source side
//   src_data          : word to transfer
//   xfer_req          : registered request toward the destination
//   xfer_data         : captured word, held until the next capture
//   xfer_ack_async    : destination ack, unsynchronized
//   xfer_done         : one-cycle pulse per transfer acked in time
//   busy              : a transfer is in progress
//   timeout_err       : sticky flag, set when ack never arrived
//   err_clr           : clears timeout_err (a new timeout wins)
module ftc_cdc_handshake_sender #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_mode_async,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack_async,
    output logic             xfer_done,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam bit          TIMEOUT_ON = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ack_s1;
    logic              ack_s2;
    logic              ack_s;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              xfer_ok;
    logic              ok_nxt;
    logic              req_nxt;
    logic [WIDTH-1:0]  data_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic              accept;
    logic              timeout_fire;

    // Ack synchronizer; in test mode both ranks load the raw ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= xfer_ack_async;
            ack_s2 <= test_mode_async ? xfer_ack_async : ack_s1;
        end
    end

    assign ack_s        = ack_s2;
    assign src_ready    = (state == ST_IDLE) && !ack_s;
    assign busy         = (state != ST_IDLE);
    assign accept       = src_valid && src_ready;
    assign timeout_fire = TIMEOUT_ON && (state == ST_REQ) && !ack_s && (cnt == CNT_LAST);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            xfer_ok     <= 1'b0;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            xfer_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            xfer_ok     <= ok_nxt;
            xfer_req    <= req_nxt;
            xfer_data   <= data_nxt;
            xfer_done   <= done_nxt;
            timeout_err <= err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                  state_nxt = ST_REQ;
            ST_REQ:  if (ack_s || timeout_fire)   state_nxt = ST_REL;
            ST_REL:  if (!ack_s)                  state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and transfer bookkeeping.
    always_comb begin
        req_nxt  = 1'b0;
        data_nxt = xfer_data;
        done_nxt = 1'b0;
        ok_nxt   = xfer_ok;
        cnt_nxt  = cnt;
        err_nxt  = timeout_err & ~err_clr;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    data_nxt = src_data;
                    req_nxt  = 1'b1;
                    cnt_nxt  = '0;
                    ok_nxt   = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    ok_nxt = 1'b1;
                end else if (timeout_fire) begin
                    ok_nxt  = 1'b0;
                    err_nxt = 1'b1;
                end else begin
                    req_nxt = 1'b1;
                    // Saturate so a disabled timeout never wraps the count.
                    if (cnt != CNT_SAT) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    done_nxt = xfer_ok;
                end
            end
            default: begin
                req_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ftc_cdc_handshake_sender.sv
// Bench for ftc_cdc_handshake_sender: table of full transfers, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_ftc_cdc_handshake_sender;

    localparam int unsigned WIDTH = 32;
    localparam int          TO    = 8;
    localparam int          P_IDLE = 0;
    localparam int          P_REQ  = 1;
    localparam int          P_REL  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             test_mode_async = 1'b0;
    logic             src_valid = 1'b0;
    logic             src_ready;
    logic [WIDTH-1:0] src_data = '0;
    logic             xfer_req;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_ack_async = 1'b0;
    logic             xfer_done;
    logic             busy;
    logic             timeout_err;
    logic             err_clr = 1'b0;

    ftc_cdc_handshake_sender #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .test_mode_async (test_mode_async),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .src_data        (src_data),
        .xfer_req        (xfer_req),
        .xfer_data       (xfer_data),
        .xfer_ack_async  (xfer_ack_async),
        .xfer_done       (xfer_done),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Destination responder
    bit dest_auto = 1'b0;
    int rise_dly  = 3;
    int fall_dly  = 3;
    int dcnt      = 0;
    bit edge_ack  = 1'b0;

    // Reference model state
    int          m_phase;
    logic [31:0] m_word;
    bit          m_req, m_done, m_err, m_ok, m_acks, m_ack_prev;
    int          m_since;

    typedef struct {
        logic        tm;
        logic [31:0] data;
        int          rise;
        int          fall;
        int          exp_lat;
    } xfer_vec_t;

    xfer_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_word = '0; m_req = 0; m_done = 0; m_err = 0;
        m_ok = 0; m_acks = 0; m_ack_prev = 0; m_since = 0;
    endtask

    // One clock edge of the protocol, from the rules: a word is taken only in
    // idle with the synchronized ack low, the request lasts until ack is seen
    // or TO cycles have passed since capture, then the release phase waits
    // for ack to drop.
    task automatic model_edge();
        bit rdy;
        bit a_s;
        rdy = (m_phase == P_IDLE) && !m_acks;
        a_s = m_acks;
        m_done = 0;
        if (err_clr) m_err = 0;
        case (m_phase)
            P_IDLE: if (src_valid && rdy) begin
                m_word = src_data; m_phase = P_REQ; m_since = 0; m_req = 1;
            end
            P_REQ: begin
                m_since++;
                if (a_s) begin
                    m_ok = 1; m_phase = P_REL; m_req = 0;
                end else if (m_since == TO) begin
                    m_ok = 0; m_err = 1; m_phase = P_REL; m_req = 0;
                end
            end
            default: if (!a_s) begin
                m_done = m_ok; m_phase = P_IDLE;
            end
        endcase
        m_acks     = test_mode_async ? xfer_ack_async : m_ack_prev;
        m_ack_prev = xfer_ack_async;
    endtask

    task automatic model_compare();
        check("m_ready", 32'(src_ready),  32'((m_phase == P_IDLE) && !m_acks));
        check("m_busy",  32'(busy),       32'(m_phase != P_IDLE));
        check("m_req",   32'(xfer_req),   32'(m_req));
        check("m_data",  xfer_data,       m_word);
        check("m_done",  32'(xfer_done),  32'(m_done));
        check("m_err",   32'(timeout_err),32'(m_err));
    endtask

    // Advance one clock: responder, edge, model, sample 1ns after the edge.
    task automatic tick();
        if (dest_auto && !rst) begin
            if (!xfer_ack_async && xfer_req) begin
                dcnt++;
                if (dcnt >= rise_dly) begin xfer_ack_async = 1'b1; dcnt = 0; end
            end else if (xfer_ack_async && !xfer_req) begin
                dcnt++;
                if (dcnt >= fall_dly) begin xfer_ack_async = 1'b0; dcnt = 0; end
            end else begin
                dcnt = 0;
            end
        end
        @(posedge clk);
        edge_ack = xfer_ack_async;
        if (rst) model_reset(); else model_edge();
        #1;
        model_compare();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || !src_ready) && k < 100) begin
            tick();
            k++;
        end
        check("wait_idle", 32'(busy || !src_ready), 32'd0);
    endtask

    task automatic do_transfer(input logic tm, input logic [31:0] data,
                               input int rise, input int fall, input int exp_lat);
        int first_ack, fall_at, dn, chg;
        test_mode_async = tm; dest_auto = 1; rise_dly = rise; fall_dly = fall;
        wait_idle();
        src_valid = 1'b1; src_data = data;
        tick();
        src_valid = 1'b0;
        check("cap_data", xfer_data, data);
        check("cap_req",  32'(xfer_req), 32'd1);
        check("cap_busy", 32'(busy), 32'd1);
        first_ack = -1; fall_at = -1; dn = 0; chg = 0;
        for (int i = 1; i <= 60; i++) begin
            if (!busy) break;
            tick();
            if (edge_ack && first_ack < 0) first_ack = i;
            if (!xfer_req && fall_at < 0) fall_at = i;
            if (xfer_done) dn++;
            if (xfer_data != data) chg++;
        end
        check("ack_to_req_fall", 32'(fall_at - first_ack + 1), 32'(exp_lat));
        check("done_pulses", 32'(dn), 32'd1);
        check("data_stable", 32'(chg), 32'd0);
        check("end_idle",  32'(busy), 32'd0);
        check("end_ready", 32'(src_ready), 32'd1);
    endtask

    task automatic back_to_back();
        logic [31:0] cur;
        int caps, dn, bad;
        bit acc;
        test_mode_async = 0; dest_auto = 1; rise_dly = 2; fall_dly = 2;
        wait_idle();
        caps = 0; dn = 0; bad = 0; cur = '0;
        src_valid = 1'b1; src_data = 32'd1;
        for (int c = 0; c < 200; c++) begin
            if (caps == 3 && !busy) break;
            acc = src_valid && src_ready;
            tick();
            if (acc) begin
                caps++;
                cur = 32'(caps);
                check("b2b_capture", xfer_data, cur);
                if (caps < 3) src_data = 32'(caps + 1); else src_valid = 1'b0;
            end
            if (xfer_done) dn++;
            if (busy && xfer_data != cur) bad++;
        end
        check("b2b_caps",  32'(caps), 32'd3);
        check("b2b_dones", 32'(dn),   32'd3);
        check("b2b_hold",  32'(bad),  32'd0);
    endtask

    task automatic timeout_seq();
        int n, dn;
        test_mode_async = 0; dest_auto = 0; xfer_ack_async = 0; err_clr = 0;
        wait_idle();
        src_valid = 1'b1; src_data = 32'hDEAD_0008;
        tick();
        src_valid = 1'b0;
        n = 0; dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (!xfer_req) break;
            tick();
            n++;
            if (xfer_done) dn++;
        end
        check("to_req_cycles", 32'(n), 32'(TO));
        check("to_err_set",    32'(timeout_err), 32'd1);
        check("to_in_rel",     32'(busy), 32'd1);
        tick();
        if (xfer_done) dn++;
        check("to_idle_next",  32'(busy), 32'd0);
        check("to_no_done",    32'(dn), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);
        // clear held across the timeout edge: the set must win
        src_valid = 1'b1; src_data = 32'hDEAD_0009;
        tick();
        src_valid = 1'b0; err_clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!xfer_req) break;
            tick();
        end
        err_clr = 1'b0;
        check("err_set_wins", 32'(timeout_err), 32'd1);
        tick(); tick();
        check("err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_clr2", 32'(timeout_err), 32'd0);
    endtask

    task automatic late_ack_seq();
        int held, k, dn;
        test_mode_async = 0; dest_auto = 0; xfer_ack_async = 0;
        wait_idle();
        src_valid = 1'b1; src_data = 32'h0000_1A7E;
        tick();
        src_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("late_still_req", 32'(xfer_req), 32'd1);
        xfer_ack_async = 1'b1;
        tick(); tick();
        check("late_timeout", 32'({xfer_req, busy, timeout_err}), 32'b011);
        held = 0; dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) held++;
            if (xfer_done) dn++;
        end
        check("late_held_rel", 32'(held), 32'd5);
        xfer_ack_async = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
            if (xfer_done) dn++;
        end
        check("late_release_cycles", 32'(k), 32'd3);
        check("late_no_done", 32'(dn), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        do_transfer(1'b0, 32'h0000_0B0B, 3, 3, 3);
    endtask

    task automatic spurious_seq();
        int cap;
        test_mode_async = 0; dest_auto = 0; xfer_ack_async = 0;
        wait_idle();
        xfer_ack_async = 1'b1;
        tick(); tick();
        check("spur_ready_low", 32'(src_ready), 32'd0);
        src_valid = 1'b1; src_data = 32'h0000_0077;
        cap = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (busy) cap++; end
        check("spur_no_capture", 32'(cap), 32'd0);
        xfer_ack_async = 1'b0;
        tick(); tick();
        check("spur_ready_back", 32'({src_ready, busy}), 32'b10);
        tick();
        src_valid = 1'b0;
        check("spur_capture", xfer_data, 32'h0000_0077);
        dest_auto = 1;
        wait_idle();
    endtask

    task automatic reset_seq();
        test_mode_async = 0; dest_auto = 1; rise_dly = 3; fall_dly = 3;
        wait_idle();
        src_valid = 1'b1; src_data = 32'h1234_ABCD;
        tick();
        src_valid = 1'b0;
        tick();
        check("pre_rst_req", 32'(xfer_req), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_req", 32'(xfer_req), 32'd0);
        check("rst_async_outs", 32'({busy, xfer_done, timeout_err, src_ready}), 32'b0001);
        check("rst_async_data", xfer_data, 32'd0);
        dest_auto = 0; xfer_ack_async = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_transfer(1'b0, 32'h0000_005A, 3, 3, 3);
    endtask

    task automatic random_run();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                test_mode_async = 1'($urandom_range(0, 1));
                dest_auto = 1'($urandom_range(0, 1));
                rise_dly = int'($urandom_range(1, 9));
                fall_dly = int'($urandom_range(1, 6));
            end
            src_valid = ($urandom_range(0, 2) != 0);
            src_data  = $urandom;
            err_clr   = ($urandom_range(0, 9) == 0);
            if (!dest_auto && $urandom_range(0, 5) == 0) xfer_ack_async = !xfer_ack_async;
            tick();
        end
        src_valid = 1'b0; err_clr = 1'b0; dest_auto = 1'b0; xfer_ack_async = 1'b0;
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{tm: 1'b0, data: 32'hA5A5_0001, rise: 3, fall: 3, exp_lat: 3};
        vecs[1] = '{tm: 1'b1, data: 32'h1234_5678, rise: 3, fall: 3, exp_lat: 2};
        vecs[2] = '{tm: 1'b0, data: 32'hFFFF_FFFF, rise: 1, fall: 1, exp_lat: 3};
        vecs[3] = '{tm: 1'b1, data: 32'h0000_0000, rise: 5, fall: 2, exp_lat: 2};
        vecs[4] = '{tm: 1'b0, data: 32'h8000_0001, rise: 5, fall: 4, exp_lat: 3};

        model_reset();
        tick(); tick();
        check("rst_req",   32'(xfer_req), 32'd0);
        check("rst_data",  xfer_data, 32'd0);
        check("rst_flags", 32'({busy, xfer_done, timeout_err}), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_transfer(vecs[i].tm, vecs[i].data, vecs[i].rise, vecs[i].fall, vecs[i].exp_lat);
        end

        back_to_back();
        timeout_seq();
        late_ack_seq();
        spurious_seq();
        reset_seq();
        random_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ftc_cdc_handshake_sender.md
Name: ftc_cdc_handshake_sender

Overview:
- Source-side controller for a four-phase req/ack transfer of a WIDTH-bit word into an asynchronous destination domain.
- Accepts words on a valid/ready interface, holds each word stable on xfer_data and sequences xfer_req.
- Brings the destination's ack back through an internal double-rank synchronizer, which is bypassed to one stage in test mode.
- Flags a timeout when ack never arrives; sits at the source edge of every multi-bit CDC path in the block.

Parameters:
- WIDTH, 32, width of the transferred word.
- TIMEOUT_CYCLES, 1023, number of REQ-state cycles allowed before timeout; 0 disables timeout.

Ports:
- clk  input  1  block clock.
- rst  input  1  asynchronous, active-high reset.
- test_mode_async  input  1  when 1, the ack synchronizer behaves as a single stage.
- src_valid  input  1  source word valid.
- src_ready  output  1  block can accept a word.
- src_data  input  WIDTH  source word.
- xfer_req  output  1  request to the destination domain; registered, glitch-free.
- xfer_data  output  WIDTH  held word; stable from capture until the next capture.
- xfer_ack_async  input  1  ack from the destination domain; asynchronous.
- xfer_done  output  1  one-cycle pulse when a transfer completes with a valid ack.
- busy  output  1  state is not IDLE.
- timeout_err  output  1  sticky timeout flag.
- err_clr  input  1  clears timeout_err.

Behaviour:
- Reset: state=IDLE, xfer_req=0, xfer_data=0, xfer_done=0, timeout_err=0, both sync flops=0, counter=0. Assertion mid-transfer drops xfer_req immediately (async reset) and discards the word.
- Ack synchronizer (normal mode): s1<=ack_async; s2<=s1; ack_s=s2. The edge sampling a change is followed by 2 clk before ack_s reflects it.
- Ack synchronizer (test_mode_async=1): s1 and s2 both load ack_async, so ack_s reflects it after 1 clk.
- FSM states: IDLE, REQ, REL.
- src_ready = (state==IDLE) && !ack_s. This is combinational from registers only; there is no dependency on src_valid.
- IDLE: on src_valid&&src_ready, capture src_data into xfer_data, go to REQ, set xfer_req=1 on the same edge, clear counter.
- REQ: xfer_req=1. When ack_s==1, go to REL with xfer_req=0 on that edge and mark the transfer ok.
- REQ timeout: if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with ack_s still 0, go to REL, set xfer_req=0, set timeout_err=1, mark the transfer failed. Otherwise counter increments each REQ cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. The counter never wraps.
- REL: xfer_req=0. When ack_s==0, go to IDLE. xfer_done pulses for 1 cycle on that edge only if the transfer was marked ok. REL has no timeout.
- Ack rising while in IDLE (spurious): ignored, but src_ready stays low until ack_s returns to 0.
- Late ack after timeout: REL waits for it to fall; no xfer_done is produced.
- timeout_err: set by timeout, cleared by err_clr. If both occur in the same cycle, set wins. Clearing has no effect on the FSM.
- busy = (state!=IDLE).
- Minimum throughput, normal mode: 1 (capture) + ≥2 (ack rise sync) + 1 + ≥2 (ack fall sync), plus destination latency.
- xfer_data never changes while xfer_req=1 or in REL.

Test Plan:
- Basic transfer: src_data=0xA5A5_0001 with a destination model that raises ack 3 clk after xfer_req and drops it 3 clk after xfer_req falls -> xfer_data=0xA5A5_0001 from capture edge+0; xfer_req high 1 clk after accept; one xfer_done pulse; src_ready returns high; busy low after.
- Back-to-back: src_valid held with 0x1, 0x2, 0x3 -> exactly three captures in order. Each new capture occurs only after ack_s is low. Three xfer_done pulses; xfer_data never changes while xfer_req=1.
- Timeout: TIMEOUT_CYCLES=8, ack tied 0 -> xfer_req falls after 8 REQ cycles; timeout_err=1; no xfer_done; IDLE 1 cycle later. err_clr pulse -> timeout_err=0. err_clr asserted on the timeout cycle -> timeout_err=1.
- Late ack after timeout: ack rises during REL and falls 5 clk later -> FSM holds REL until ack_s=0; no xfer_done; next word accepted.
- Test mode: test_mode_async=1 -> ack-rise-to-xfer_req-fall latency is 2 clk instead of 3 clk in normal mode. Measure both.
- Reset mid-transfer: assert rst while in REQ -> xfer_req=0 asynchronously before the next edge; all outputs at reset values. After release, a new transfer of 0x5A completes normally.
